// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-stage types, instruction field positions and reset PC default
package cpu_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, FAULT} ifu_state_e;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;
  localparam int RD_MSB = 15;
  localparam int RD_LSB = 11;
  localparam int FUNC_MSB = 5;
  localparam int IMM_MSB = 15;
  localparam int JT_MSB = 25;
endpackage

// File: rtl/ifu_next_pc.sv
// ifu_next_pc: combinational next-PC select (jump > taken branch > sequential)
// Ports: pc_plus4, instr, branch, jump, zero in; next_pc out.
module ifu_next_pc
  import cpu_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] instr,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero,
  output logic [31:0] next_pc
);
  logic [31:0] br_off;
  assign br_off  = {{14{instr[IMM_MSB]}}, instr[IMM_MSB:0], 2'b00};
  assign next_pc = jump ? {pc_plus4[31:28], instr[JT_MSB:0], 2'b00} :
                   (branch && zero) ? pc_plus4 + br_off : pc_plus4;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: multi-cycle fetch stage feeding decode, with sticky imem timeout fault
// Ports: clk/rst_n; imem_req/addr/ready/rdata memory handshake; instr_valid, instr and
// decoded fields, pc, pc_plus4 to decode; exec_done/branch/jump/zero feedback; fetch_err.
// Optional IFU_PERF_CNT_EN adds fetch_cnt and stall_cnt performance counters.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = RESET_PC_DEF,
  parameter int          IMEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  func,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm16,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        exec_done,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero,
`ifdef IFU_PERF_CNT_EN
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt,
`endif
  output logic        fetch_err
);
  ifu_state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, cnt_q, cnt_d, next_pc;
  logic err_q, err_d, timeout_hit;
  ifu_next_pc u_next_pc (
    .pc_plus4(pc_plus4),
    .instr   (instr_q),
    .branch  (branch),
    .jump    (jump),
    .zero    (zero),
    .next_pc (next_pc)
  );
  assign timeout_hit = (IMEM_TIMEOUT != 0) && (cnt_q + 32'd1 == 32'(IMEM_TIMEOUT));
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
        cnt_d   = '0;
      end
      FETCH: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          state_d = ISSUE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = FAULT;
        end else cnt_d = cnt_q + 32'd1;
      end
      ISSUE: begin
        if (exec_done) begin
          pc_d    = next_pc;
          state_d = FETCH;
          cnt_d   = '0;
        end
      end
      FAULT: state_d = FAULT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end
`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else if (state_q == FETCH) begin
      fetch_cnt_q <= fetch_cnt_q + {31'd0, imem_ready};
      stall_cnt_q <= stall_cnt_q + {31'd0, !imem_ready};
    end
  end
  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif
  assign imem_req    = state_q == FETCH;
  assign imem_addr   = pc_q;
  assign instr_valid = state_q == ISSUE;
  assign instr       = instr_q;
  assign op          = instr_q[OP_MSB:OP_LSB];
  assign rs          = instr_q[RS_MSB:RS_LSB];
  assign rt          = instr_q[RT_MSB:RT_LSB];
  assign rd          = instr_q[RD_MSB:RD_LSB];
  assign func        = instr_q[FUNC_MSB:0];
  assign imm16       = instr_q[IMM_MSB:0];
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign fetch_err   = err_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scoreboard bench for instr_fetch_unit (main instance plus a wrap/no-timeout instance)
module tb_instr_fetch_unit;
  logic clk = 1'b0, rst_n = 1'b0;
  logic imem_req, imem_ready = 1'b0, instr_valid, exec_done = 1'b0, branch = 1'b0, jump = 1'b0, zero = 1'b0, fetch_err;
  logic [31:0] imem_addr, imem_rdata = '0, instr, pc, pc_plus4;
  logic [5:0] op, func;
  logic [4:0] rs, rt, rd;
  logic [15:0] imm16;
  logic w_req, w_ready = 1'b0, w_valid, w_exec = 1'b0, w_err;
  logic [31:0] w_addr, w_rdata = '0, w_instr, w_pc, w_pc4;
  logic [5:0] w_op, w_func;
  logic [4:0] w_rs, w_rt, w_rd;
  logic [15:0] w_imm;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt, stall_cnt, w_fcnt, w_scnt;
`endif
  int checks = 0, errors = 0;
  typedef struct { logic [31:0] addr; logic [31:0] data; } fetch_t;
  fetch_t sb[$];

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr(instr), .op(op), .func(func), .rs(rs), .rt(rt), .rd(rd), .imm16(imm16),
    .pc(pc), .pc_plus4(pc_plus4), .exec_done(exec_done), .branch(branch),
    .jump(jump), .zero(zero),
`ifdef IFU_PERF_CNT_EN
    .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt),
`endif
    .fetch_err(fetch_err)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .IMEM_TIMEOUT(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ready(w_ready), .imem_rdata(w_rdata), .instr_valid(w_valid),
    .instr(w_instr), .op(w_op), .func(w_func), .rs(w_rs), .rt(w_rt), .rd(w_rd), .imm16(w_imm),
    .pc(w_pc), .pc_plus4(w_pc4), .exec_done(w_exec), .branch(1'b0),
    .jump(1'b0), .zero(1'b0),
`ifdef IFU_PERF_CNT_EN
    .fetch_cnt(w_fcnt), .stall_cnt(w_scnt),
`endif
    .fetch_err(w_err)
  );

  // Serve one fetch at addr after 'waits' not-ready cycles; scoreboard checks the captured word.
  task automatic serve(input logic [31:0] addr, input logic [31:0] data, input int waits);
    int n = 0;
    fetch_t e;
    logic [31:0] d;
    while (imem_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (imem_req !== 1'b1) begin
      errors++; $display("FAIL req_wait: imem_req=%b expected 1", imem_req); return;
    end
    for (int i = 0; i <= waits; i++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== addr || instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL req_hold[%0d]: req=%b addr=%h valid=%b expected req=1 addr=%h valid=0", i, imem_req, imem_addr, instr_valid, addr);
      end
      imem_ready = (i == waits);
      imem_rdata = (i == waits) ? data : ~data;
      if (i == waits) sb.push_back('{addr, data});
      @(negedge clk);
    end
    imem_ready = 1'b0;
    imem_rdata = $urandom;
    checks++;
    if (instr_valid !== 1'b1 || imem_req !== 1'b0 || sb.size() == 0) begin
      errors++; $display("FAIL issue: valid=%b req=%b expected valid=1 req=0", instr_valid, imem_req);
    end else begin
      e = sb.pop_front();
      d = e.data;
      checks++;
      if (instr !== d || pc !== e.addr || pc_plus4 !== e.addr + 32'd4 ||
          {op, rs, rt, rd, func, imm16} !== {d[31:26], d[25:21], d[20:16], d[15:11], d[5:0], d[15:0]}) begin
        errors++;
        $display("FAIL capture: instr=%h pc=%h pc4=%h op=%h func=%h imm=%h expected instr=%h pc=%h", instr, pc, pc_plus4, op, func, imm16, d, e.addr);
      end
    end
  endtask

  // Hold ISSUE one cycle with noisy feedback, then retire with given feedback and check the next fetch address.
  task automatic exec(input logic b, input logic j, input logic z, input logic [31:0] nxt);
    logic [31:0] pc0 = pc;
    branch = 1'($urandom); jump = 1'($urandom); zero = 1'($urandom);
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b1 || imem_req !== 1'b0 || pc !== pc0) begin
      errors++; $display("FAIL issue_hold: valid=%b req=%b pc=%h expected valid=1 req=0 pc=%h", instr_valid, imem_req, pc, pc0);
    end
    exec_done = 1'b1; branch = b; jump = j; zero = z;
    @(negedge clk);
    exec_done = 1'b0; branch = 1'($urandom); jump = 1'($urandom); zero = 1'($urandom);
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== nxt || pc !== nxt) begin
      errors++; $display("FAIL next_pc: valid=%b req=%b addr=%h pc=%h expected valid=0 req=1 addr=%h", instr_valid, imem_req, imem_addr, pc, nxt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || fetch_err !== 1'b0 || instr !== 32'd0 ||
        pc !== 32'd0 || {op, func, rs, rt, rd, imm16} !== 43'd0) begin
      errors++; $display("FAIL reset: req=%b valid=%b err=%b instr=%h pc=%h expected all 0", imem_req, instr_valid, fetch_err, instr, pc);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
      errors++; $display("FAIL idle_to_fetch: req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr);
    end
  endtask

  task automatic test_zero_wait();
    serve(32'h0, 32'h0000_0020, 0);
    checks++;
    if (op !== 6'h00 || func !== 6'h20 || pc !== 32'h0) begin
      errors++; $display("FAIL add_fields: op=%h func=%h pc=%h expected op=00 func=20 pc=0", op, func, pc);
    end
    exec(1'b0, 1'b0, 1'b0, 32'h4);
  endtask

  task automatic test_wait_states();
    serve(32'h4, 32'h0800_0010, 3);
    exec(1'b0, 1'b1, 1'b0, 32'h40);
  endtask

  task automatic test_branch();
    serve(32'h40, 32'h1000_FFFE, 0);
    exec(1'b1, 1'b0, 1'b1, 32'h3C);
    serve(32'h3C, 32'h1000_FFFE, 1);
    exec(1'b1, 1'b0, 1'b0, 32'h40);
    serve(32'h40, 32'h1000_FFFE, 0);
    exec(1'b1, 1'b0, 1'b0, 32'h44);
  endtask

  task automatic test_jump();
    serve(32'h44, 32'h0BFF_FFFF, 0);
    exec(1'b0, 1'b1, 1'b0, 32'h0FFF_FFFC);
    serve(32'h0FFF_FFFC, 32'h0000_0020, 0);
    exec(1'b0, 1'b0, 1'b0, 32'h1000_0000);
    serve(32'h1000_0000, 32'h0800_0100, 2);
    exec(1'b1, 1'b1, 1'b1, 32'h1000_0400);
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (imem_req !== 1'b1 || fetch_err !== 1'b0) begin
        errors++; $display("FAIL pre_timeout[%0d]: req=%b err=%b expected req=1 err=0", i, imem_req, fetch_err);
      end
      @(negedge clk);
    end
    exec_done = 1'b1; jump = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h1000_0400) begin
        errors++; $display("FAIL fault[%0d]: err=%b req=%b valid=%b pc=%h expected err=1 req=0 valid=0 pc=10000400", i, fetch_err, imem_req, instr_valid, pc);
      end
      @(negedge clk);
    end
    exec_done = 1'b0; jump = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (fetch_err !== 1'b0 || pc !== 32'h0 || imem_req !== 1'b0 || instr !== 32'h0) begin
      errors++; $display("FAIL fault_reset: err=%b pc=%h req=%b instr=%h expected 0", fetch_err, pc, imem_req, instr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    serve(32'h0, 32'h0000_0020, 0);
    exec(1'b0, 1'b0, 1'b0, 32'h4);
  endtask

`ifdef IFU_PERF_CNT_EN
  task automatic test_perf();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    serve(32'h0, 32'h0000_0020, 2);
    exec(1'b0, 1'b0, 1'b0, 32'h4);
    serve(32'h4, 32'h0000_0020, 3);
    exec(1'b0, 1'b0, 1'b0, 32'h8);
    checks++;
    if (fetch_cnt !== 32'd2 || stall_cnt !== 32'd5) begin
      errors++; $display("FAIL perf_cnt: fetch_cnt=%0d stall_cnt=%0d expected 2 and 5", fetch_cnt, stall_cnt);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (fetch_cnt !== 32'd0 || stall_cnt !== 32'd0 || imem_req !== 1'b0 || instr_valid !== 1'b0 ||
        instr !== 32'd0 || pc !== 32'd0 || fetch_err !== 1'b0) begin
      errors++; $display("FAIL perf_reset: fcnt=%0d scnt=%0d req=%b valid=%b instr=%h pc=%h expected 0", fetch_cnt, stall_cnt, imem_req, instr_valid, instr, pc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    serve(32'h0, 32'h0000_0020, 0);
  endtask
`endif

  task automatic test_wrap();
    repeat (30) @(negedge clk);
    checks++;
    if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC || w_err !== 1'b0) begin
      errors++; $display("FAIL no_timeout: req=%b addr=%h err=%b expected req=1 addr=fffffffc err=0", w_req, w_addr, w_err);
    end
    w_ready = 1'b1; w_rdata = 32'h0000_0020;
    @(negedge clk);
    w_ready = 1'b0;
    checks++;
    if (w_valid !== 1'b1 || w_instr !== 32'h0000_0020 || w_pc4 !== 32'h0) begin
      errors++; $display("FAIL wrap_issue: valid=%b instr=%h pc4=%h expected valid=1 instr=20 pc4=0", w_valid, w_instr, w_pc4);
    end
    w_exec = 1'b1;
    @(negedge clk);
    w_exec = 1'b0;
    checks++;
    if (w_req !== 1'b1 || w_addr !== 32'h0 || w_pc !== 32'h0 || w_err !== 1'b0) begin
      errors++; $display("FAIL wrap: req=%b addr=%h pc=%h err=%b expected req=1 addr=0 pc=0 err=0", w_req, w_addr, w_pc, w_err);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_branch();
    test_jump();
    test_timeout();
`ifdef IFU_PERF_CNT_EN
    test_perf();
`endif
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
